calc_n: RTL and testbench

CALC_N -- requirements
Module: calc_n

---
 rtl/calc_n.sv | 171 +++++++++++++++++
 tb/tb_calc_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_n.sv
// calc_n: multi-port calculator sharing one registered ALU.
// Each port takes a command plus operand 1, then operand 2 on the next edge,
// then waits for a round-robin grant of the shared ALU. The result is shown on
// that port's outputs for exactly one cycle.
// Ports:
//   c_clk       - clock, rising edge
//   reset       - asynchronous, active-high reset
//   req_cmd_in  - per-port 4-bit command, port i at [i*4 +: 4]
//   req_data_in - per-port operand, port i at [i*DATA_W +: DATA_W]
//   out_resp    - per-port response: 0 none, 1 success, 2 error
//   out_data    - per-port result
//   port_busy   - per-port: request accepted and not yet answered
module calc_n #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int SH_W      = $clog2(DATA_W)
) (
   input  logic                        c_clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*4-1:0]      req_cmd_in,
   input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
   output logic [NUM_PORTS*2-1:0]      out_resp,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS-1:0]        port_busy
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OP2,
      S_PEND
   } state_t;

   state_t                    r_state     [NUM_PORTS];
   state_t                    w_state_nxt [NUM_PORTS];
   logic [3:0]                r_cmd       [NUM_PORTS];
   logic [DATA_W-1:0]         r_op1       [NUM_PORTS];
   logic [DATA_W-1:0]         r_op2       [NUM_PORTS];
   logic [PTR_W-1:0]          r_ptr;
   logic [NUM_PORTS*2-1:0]    r_resp;
   logic [NUM_PORTS*DATA_W-1:0] r_data;

   logic                      w_gnt_vld;
   logic [NUM_PORTS-1:0]      w_gnt;
   logic [PTR_W-1:0]          w_gnt_idx;
   logic [PTR_W-1:0]          w_ptr_nxt;
   logic [3:0]                w_sel_cmd;
   logic [DATA_W-1:0]         w_sel_op1;
   logic [DATA_W-1:0]         w_sel_op2;
   logic [DATA_W:0]           w_sum;
   logic [1:0]                w_res_resp;
   logic [DATA_W-1:0]         w_res_data;

   // Round-robin: scan from r_ptr, first PEND port wins; pointer then moves
   // to the port after the winner.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_ptr_nxt = r_ptr;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         idx = (32'(r_ptr) + k) % NUM_PORTS;
         if (!w_gnt_vld && r_state[idx] == S_PEND) begin
            w_gnt_vld  = 1'b1;
            w_gnt[idx] = 1'b1;
            w_gnt_idx  = PTR_W'(idx);
            w_ptr_nxt  = PTR_W'((idx + 1) % NUM_PORTS);
         end
      end
   end

   // Shared ALU operates on the granted port's latched request.
   assign w_sel_cmd = r_cmd[w_gnt_idx];
   assign w_sel_op1 = r_op1[w_gnt_idx];
   assign w_sel_op2 = r_op2[w_gnt_idx];
   assign w_sum     = {1'b0, w_sel_op1} + {1'b0, w_sel_op2};

   always_comb begin
      w_res_resp = RESP_ERR;
      w_res_data = '0;
      case (w_sel_cmd)
         CMD_ADD: begin
            if (!w_sum[DATA_W]) begin
               w_res_resp = RESP_OK;
               w_res_data = w_sum[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (w_sel_op2 <= w_sel_op1) begin
               w_res_resp = RESP_OK;
               w_res_data = w_sel_op1 - w_sel_op2;
            end
         end
         CMD_SHL: begin
            w_res_resp = RESP_OK;
            w_res_data = w_sel_op1 << w_sel_op2[SH_W-1:0];
         end
         CMD_SHR: begin
            w_res_resp = RESP_OK;
            w_res_data = w_sel_op1 >> w_sel_op2[SH_W-1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            S_IDLE:  if (req_cmd_in[i*4 +: 4] != CMD_NOP) w_state_nxt[i] = S_OP2;
            S_OP2:   w_state_nxt[i] = S_PEND;
            S_PEND:  if (w_gnt[i]) w_state_nxt[i] = S_IDLE;
            default: w_state_nxt[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) r_state[i] <= S_IDLE;
         r_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) r_state[i] <= w_state_nxt[i];
         if (w_gnt_vld) r_ptr <= w_ptr_nxt;
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            r_cmd[i] <= '0;
            r_op1[i] <= '0;
            r_op2[i] <= '0;
         end
         r_resp <= '0;
         r_data <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (r_state[i] == S_IDLE && req_cmd_in[i*4 +: 4] != CMD_NOP) begin
               r_cmd[i] <= req_cmd_in[i*4 +: 4];
               r_op1[i] <= req_data_in[i*DATA_W +: DATA_W];
            end
            if (r_state[i] == S_OP2) r_op2[i] <= req_data_in[i*DATA_W +: DATA_W];
            // Every port's result register clears each edge unless granted now.
            r_resp[i*2 +: 2]           <= w_gnt[i] ? w_res_resp : RESP_NONE;
            r_data[i*DATA_W +: DATA_W] <= w_gnt[i] ? w_res_data : '0;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) port_busy[i] = (r_state[i] != S_IDLE);
   end

   assign out_resp = r_resp;
   assign out_data = r_data;

endmodule

// File: tb/tb_calc_n.sv
// tb_calc_n: directed and randomized checks of calc_n against a timestamp-based
// reference model (request edge, operand-2 edge, earliest grant edge) with
// plain arithmetic for the results.
module tb_calc_n;

   localparam int NP = 4;
   localparam int DW = 32;

   logic             c_clk;
   logic             reset;
   logic [NP*4-1:0]  req_cmd_in;
   logic [NP*DW-1:0] req_data_in;
   logic [NP*2-1:0]  out_resp;
   logic [NP*DW-1:0] out_data;
   logic [NP-1:0]    port_busy;

   int n_tests;
   int n_fail;

   // reference model state
   int          cyc;
   bit          m_act  [NP];
   int          m_t0   [NP];
   logic [3:0]  m_cmd  [NP];
   logic [31:0] m_op1  [NP];
   logic [31:0] m_op2  [NP];
   logic [1:0]  m_resp [NP];
   logic [31:0] m_data [NP];
   int          m_ptr;

   calc_n #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .port_busy   (port_busy)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   initial begin
      #400000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
      logic [63:0] s;
      r = 2'd2;
      d = 32'd0;
      case (c)
         4'd1: begin
            s = {32'd0, a} + {32'd0, b};
            if (s < 64'h1_0000_0000) begin r = 2'd1; d = s[31:0]; end
         end
         4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
         4'd5: begin r = 2'd1; d = a << (b % 32); end
         4'd6: begin r = 2'd1; d = a >> (b % 32); end
         default: ;
      endcase
   endfunction

   function automatic void model_reset();
      for (int p = 0; p < NP; p++) begin
         m_act[p]  = 1'b0;
         m_t0[p]   = 0;
         m_cmd[p]  = '0;
         m_op1[p]  = '0;
         m_op2[p]  = '0;
         m_resp[p] = '0;
         m_data[p] = '0;
      end
      m_ptr = 0;
   endfunction

   function automatic void model_edge();
      bit pre_act [NP];
      int g;
      cyc++;
      if (reset) begin
         model_reset();
         return;
      end
      g = -1;
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (m_ptr + k) % NP;
         if (g < 0 && m_act[p] && cyc >= m_t0[p] + 2) g = p;
      end
      for (int p = 0; p < NP; p++) begin
         pre_act[p] = m_act[p];
         m_resp[p]  = 2'd0;
         m_data[p]  = 32'd0;
      end
      if (g >= 0) begin
         calc(m_cmd[g], m_op1[g], m_op2[g], m_resp[g], m_data[g]);
         m_act[g] = 1'b0;
         m_ptr    = (g + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
         if (pre_act[p] && cyc == m_t0[p] + 1) m_op2[p] = req_data_in[p*DW +: DW];
         if (!pre_act[p] && req_cmd_in[p*4 +: 4] != 4'd0) begin
            m_act[p] = 1'b1;
            m_t0[p]  = cyc;
            m_cmd[p] = req_cmd_in[p*4 +: 4];
            m_op1[p] = req_data_in[p*DW +: DW];
         end
      end
   endfunction

   task automatic chk(input string tag, input int p, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s port %0d: got %0h expected %0h", tag, p, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int p = 0; p < NP; p++) begin
         chk("model_resp", p, 64'(out_resp[p*2 +: 2]), 64'(m_resp[p]));
         chk("model_data", p, 64'(out_data[p*DW +: DW]), 64'(m_data[p]));
         chk("model_busy", p, 64'(port_busy[p]), 64'(m_act[p]));
      end
   endtask

   task automatic step();
      @(posedge c_clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Requires all ports idle; checks exact 2-cycle latency and one-cycle hold.
   task automatic single(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
      req_cmd_in  = '0;
      req_data_in = '0;
      req_cmd_in[p*4 +: 4]   = c;
      req_data_in[p*DW +: DW] = a;
      step();
      req_cmd_in = '0;
      req_data_in[p*DW +: DW] = b;
      step();
      chk("busy_op2", p, 64'(port_busy[p]), 64'd1);
      chk("resp_early", p, 64'(out_resp[p*2 +: 2]), 64'd0);
      req_data_in = '0;
      step();
      chk("resp", p, 64'(out_resp[p*2 +: 2]), 64'(er));
      chk("data", p, 64'(out_data[p*DW +: DW]), 64'(ed));
      chk("busy_grant", p, 64'(port_busy[p]), 64'd0);
      step();
      chk("resp_hold", p, 64'(out_resp[p*2 +: 2]), 64'd0);
      chk("data_hold", p, 64'(out_data[p*DW +: DW]), 64'd0);
   endtask

   // All ports issue add 1+1 together; grants must rotate starting at 'first'.
   task automatic burst(input int first);
      req_cmd_in  = {NP{4'd1}};
      req_data_in = {NP{32'd1}};
      step();
      req_cmd_in = '0;
      step();
      req_data_in = '0;
      for (int j = 0; j < NP; j++) begin
         int ep;
         step();
         ep = (first + j) % NP;
         for (int p = 0; p < NP; p++) begin
            chk("burst_resp", p, 64'(out_resp[p*2 +: 2]), (p == ep) ? 64'd1 : 64'd0);
            chk("burst_data", p, 64'(out_data[p*DW +: DW]), (p == ep) ? 64'd2 : 64'd0);
            chk("burst_busy", p, 64'(port_busy[p]), (((p - first + NP) % NP) <= j) ? 64'd0 : 64'd1);
         end
      end
      step();
   endtask

   initial begin
      logic [3:0] codes [10];
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      codes   = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd15};
      model_reset();
      reset       = 1'b1;
      req_cmd_in  = '0;
      req_data_in = '0;
      #1;
      chk("reset_resp", 0, 64'(out_resp), 64'd0);
      chk("reset_data", 0, 64'(out_data[63:0]), 64'd0);
      chk("reset_busy", 0, 64'(port_busy), 64'd0);
      step();
      step();
      reset = 1'b0;

      // round robin from pointer 0, then from port 1 after a lone port-0 grant
      burst(0);
      single(0, 4'd1, 32'h1, 32'h1FF_FFFF, 2'd1, 32'h200_0000);
      burst(1);

      for (int p = 0; p < NP; p++) single(p, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'd0);
      single(1, 4'd2, 32'd1, 32'd15, 2'd2, 32'd0);
      single(2, 4'd2, 32'd15, 32'd1, 2'd1, 32'd14);
      single(3, 4'd2, 32'd7, 32'd7, 2'd1, 32'd0);
      single(0, 4'd3, 32'd5, 32'd6, 2'd2, 32'd0);
      single(1, 4'd4, 32'd5, 32'd6, 2'd2, 32'd0);
      single(2, 4'd5, 32'h1, 32'd31, 2'd1, 32'h8000_0000);
      single(3, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1);
      single(0, 4'd5, 32'h1, 32'd33, 2'd1, 32'h2);
      for (int k = 0; k < 32; k++) begin
         logic [31:0] one;
         one = 32'd1;
         single(k % NP, 4'd5, 32'h1, 32'(k), 2'd1, one << k);
      end

      // randomized traffic, commands on busy ports included
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NP; p++) begin
            int sel;
            req_cmd_in[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 9)] : 4'd0;
            sel = int'($urandom_range(0, 3));
            case (sel)
               0: req_data_in[p*DW +: DW] = $urandom_range(0, 40);
               1: req_data_in[p*DW +: DW] = 32'hFFFF_FFFF - $urandom_range(0, 3);
               default: req_data_in[p*DW +: DW] = $urandom;
            endcase
         end
         step();
      end
      req_cmd_in  = '0;
      req_data_in = '0;
      repeat (12) step();

      // asynchronous reset while port 2 is pending
      req_cmd_in[2*4 +: 4]    = 4'd1;
      req_data_in[2*DW +: DW] = 32'd9;
      step();
      req_cmd_in = '0;
      step();
      req_data_in = '0;
      chk("pend_busy", 2, 64'(port_busy[2]), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("arst_resp", 2, 64'(out_resp), 64'd0);
      chk("arst_data", 2, 64'(out_data[2*DW +: DW]), 64'd0);
      chk("arst_busy", 2, 64'(port_busy), 64'd0);
      req_cmd_in  = {NP{4'd1}};
      req_data_in = {NP{32'd3}};
      step();
      step();
      req_cmd_in  = '0;
      req_data_in = '0;
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step();
         chk("no_p2_resp", 2, 64'(out_resp[2*2 +: 2]), 64'd0);
      end
      single(0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
